// File: rtl/program_loader_if.sv
// Handshake and memory-write bundle between a byte producer and the program loader.
// The master side drives the session request and the byte stream; the slave is the loader.
interface program_loader_if;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;
  logic        err_len;

  modport master (
    output start, base_addr, length, in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, checksum, err_len
  );

  modport slave (
    input  start, base_addr, length, in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, checksum, err_len
  );
endinterface

// File: rtl/program_loader.sv
// Streams a length-bounded run of program bytes into program memory from base_addr upward,
// holding the CPU while loading and keeping a modulo-256 checksum of the accepted bytes.
module program_loader (
  input  logic           clk,
  input  logic           reset,
  program_loader_if.slave bus
);
  localparam logic [12:0] MAX_LEN = 13'd4096;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state;
  logic [11:0] addr_cnt;
  logic [12:0] remaining;
  logic        xfer;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign bus.in_ready = (state == LOAD);
  assign bus.busy     = (state == LOAD);
  assign bus.cpu_hold = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign xfer         = bus.in_valid && (state == LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_cnt     <= 12'd0;
      remaining    <= 13'd0;
      bus.checksum <= 8'd0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= 12'd0;
      bus.mem_data <= 8'd0;
      bus.err_len  <= 1'b0;
    end else begin
      // Write stage: the transfer lands in memory one cycle after acceptance
      bus.mem_we  <= xfer;
      bus.err_len <= 1'b0;
      if (xfer) begin
        bus.mem_addr <= addr_cnt;
        bus.mem_data <= bus.in_byte;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.length == 13'd0) begin
              state        <= DONE;
              bus.checksum <= 8'd0;
            end else if (bus.length > MAX_LEN) begin
              bus.err_len <= 1'b1;
            end else begin
              state        <= LOAD;
              addr_cnt     <= bus.base_addr;
              remaining    <= bus.length;
              bus.checksum <= 8'd0;
            end
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            addr_cnt     <= addr_cnt + 12'd1;
            remaining    <= remaining - 13'd1;
            bus.checksum <= csum_add(bus.checksum, bus.in_byte);
            if (remaining == 13'd1) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized sessions for program_loader, checked against an address/checksum
// model built from the byte list of each session.
module tb_program_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if bus();

  program_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0]  stim_q[$];
  logic [19:0] wr_q[$];

  // Passive monitor: every write and done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_data});
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_mem_we"},   bus.mem_we,   0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_data"}, bus.mem_data, 0);
    check({tag, "_cpu_hold"}, bus.cpu_hold, 0);
    check({tag, "_busy"},     bus.busy,     0);
    check({tag, "_done"},     bus.done,     0);
    check({tag, "_err_len"},  bus.err_len,  0);
    check({tag, "_checksum"}, bus.checksum, 0);
  endtask

  // Runs one session with the bytes in stim_q and compares the resulting writes with the model
  task automatic run_session(input logic [11:0] base, input int stall_pct,
                             input bit hold_valid, input bit poke_start);
    int n     = stim_q.size();
    int wbase = wr_q.size();
    int dbase = done_cnt;
    int idx   = 0;
    int cyc   = 0;
    int exp_sum = 0;
    bus.base_addr = base;
    bus.length    = 13'(n);
    bus.start     = 1'b1;
    tick;
    bus.start = 1'b0;
    check("load_busy", bus.busy, 1);
    check("load_in_ready", bus.in_ready, 1);
    while (idx < n && cyc < 20000) begin
      if (int'($urandom_range(99)) < stall_pct) begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_byte  = stim_q[idx];
        idx++;
      end
      if (poke_start) begin
        bus.start     = 1'b1;
        bus.base_addr = 12'($urandom);
        bus.length    = 13'd1;
      end
      tick;
      cyc++;
    end
    bus.start = 1'b0;
    check("bytes_offered", idx, n);
    bus.in_valid = hold_valid;
    bus.in_byte  = 8'hEE;
    check("done_pulse", bus.done, 1);
    check("done_in_ready", bus.in_ready, 0);
    check("done_cpu_hold", bus.cpu_hold, 1);
    check("done_busy", bus.busy, 0);
    check("done_last_write", bus.mem_we, 1);
    tick;
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_done", bus.done, 0);
    check("idle_cpu_hold", bus.cpu_hold, 0);
    tick;
    bus.in_valid = 1'b0;
    check("write_count", wr_q.size() - wbase, n);
    for (int i = 0; i < n && (wbase + i) < wr_q.size(); i++) begin
      check("write_addr", wr_q[wbase + i][19:8], (int'(base) + i) % 4096);
      check("write_data", wr_q[wbase + i][7:0], stim_q[i]);
    end
    for (int i = 0; i < n; i++) exp_sum = (exp_sum + int'(stim_q[i])) % 256;
    check("checksum", bus.checksum, exp_sum);
    check("done_count", done_cnt - dbase, 1);
  endtask

  initial begin
    int wbase;
    int dbase;
    logic [7:0] cs;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = 12'd0;
    bus.length    = 13'd0;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'd0;
    tick;
    tick;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick;

    // Basic back-to-back load
    stim_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_session(12'h000, 0, 1'b0, 1'b0);
    check("basic_csum", bus.checksum, 8'h14);
    tick; tick; tick;
    check("csum_hold_idle", bus.checksum, 8'h14);

    // Stalled load
    stim_q = '{8'hFF, 8'h02};
    run_session(12'h040, 60, 1'b0, 1'b0);
    check("stall_csum", bus.checksum, 8'h01);

    // Address wrap
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(12'hFFE, 0, 1'b0, 1'b0);
    check("wrap_csum", bus.checksum, 8'h0A);

    // Oversized length: error pulse, no session, checksum untouched
    cs = bus.checksum;
    bus.length = 13'h1001;
    bus.start  = 1'b1;
    tick;
    bus.start = 1'b0;
    check("errlen_pulse", bus.err_len, 1);
    check("errlen_in_ready", bus.in_ready, 0);
    check("errlen_busy", bus.busy, 0);
    check("errlen_cpu_hold", bus.cpu_hold, 0);
    tick;
    check("errlen_clear", bus.err_len, 0);
    check("errlen_in_ready2", bus.in_ready, 0);
    check("errlen_csum", bus.checksum, cs);

    // Zero length: straight to DONE, no writes, checksum cleared
    wbase = wr_q.size();
    dbase = done_cnt;
    bus.length = 13'd0;
    bus.start  = 1'b1;
    tick;
    bus.start = 1'b0;
    check("len0_done", bus.done, 1);
    check("len0_in_ready", bus.in_ready, 0);
    check("len0_cpu_hold", bus.cpu_hold, 1);
    tick;
    check("len0_done_clear", bus.done, 0);
    tick;
    check("len0_writes", wr_q.size() - wbase, 0);
    check("len0_done_count", done_cnt - dbase, 1);
    check("len0_csum", bus.checksum, 0);

    // Extra bytes offered and start poked during LOAD
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
    run_session(12'($urandom), 0, 1'b1, 1'b1);

    // Abort on the second transfer
    wbase = wr_q.size();
    bus.base_addr = 12'h100;
    bus.length    = 13'd4;
    bus.start     = 1'b1;
    tick;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hA1;
    tick;
    bus.in_byte = 8'hB2;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_outputs("abort");
    tick;
    check("abort_writes", wr_q.size() - wbase, 1);
    check("abort_write", wr_q[wr_q.size() - 1], {12'h100, 8'hA1});

    // Randomized sessions, including the maximum length
    for (int s = 0; s < 20; s++) begin
      int n = int'($urandom_range(1, 24));
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
      run_session(12'($urandom), 30, 1'($urandom), 1'($urandom));
    end
    stim_q.delete();
    for (int i = 0; i < 4096; i++) stim_q.push_back(8'($urandom));
    run_session(12'($urandom), 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port: start  input  1  request to begin a load session; sampled in IDLE only.
REQ-004 SHALL have port: base_addr  input  12  first program-memory address of the session.
REQ-005 SHALL have port: length  input  13  byte count of the session; legal range 0..4096.
REQ-006 SHALL have port: in_valid  input  1  producer has a program byte on in_byte.
REQ-007 SHALL have port: in_byte  input  8  program byte, instr in [7:4], oprnd in [3:0].
REQ-008 SHALL have port: in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port: mem_we  output  1  program-memory write strobe, one cycle per byte.
REQ-010 SHALL have port: mem_addr  output  12  program-memory write address.
REQ-011 SHALL have port: mem_data  output  8  program-memory write data.
REQ-012 SHALL have port: cpu_hold  output  1  holds program counter and fetch register (drives ENPC/ENF low externally).
REQ-013 SHALL have port: busy  output  1  session in progress (state LOAD).
REQ-014 SHALL have port: done  output  1  one-cycle pulse at session end.
REQ-015 SHALL have port: checksum  output  8  running modulo-256 sum of accepted bytes.
REQ-016 SHALL have port: err_len  output  1  one-cycle pulse when start is given with length > 4096.

Function
REQ-017 SHALL implement states IDLE, LOAD, DONE.
REQ-018 IDLE: start=1 with 1 <= length <= 4096 -> LOAD next cycle; addr counter <= base_addr, remaining <= length, checksum <= 0.
REQ-019 IDLE: start=1 with length=0 -> DONE next cycle; no writes; checksum <= 0.
REQ-020 IDLE: start=1 with length > 4096 -> remain IDLE; err_len=1 for exactly the next cycle; checksum unchanged.
REQ-021 in_ready SHALL equal (state==LOAD), combinationally from state.
REQ-022 Transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; no other cycle changes addr, remaining or checksum.
REQ-023 Each transfer SHALL produce mem_we=1 on the following cycle with mem_addr=address of the transfer and mem_data=in_byte of the transfer (1-cycle latency); mem_we=0 on all other cycles.
REQ-024 After each transfer the address counter SHALL increment by 1 modulo 4096 (4095 -> 0 wraps).
REQ-025 After each transfer checksum SHALL become (checksum + in_byte) mod 256, visible the following cycle.
REQ-026 On the transfer that makes remaining reach 0, state SHALL go to DONE next cycle; in_ready then drops, so no extra byte is accepted.
REQ-027 in_valid=0 in LOAD SHALL stall indefinitely with no state change.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 start asserted in LOAD or DONE SHALL be ignored.
REQ-030 busy=1 only in LOAD; cpu_hold=1 in LOAD and DONE, covering the final write.
REQ-031 checksum SHALL hold its value in IDLE after a session until the next accepted start.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=0, busy=0, done=0, err_len=0, checksum=0, regardless of state.
REQ-033 reset during LOAD SHALL abort the session; a write pending from the reset-edge transfer SHALL be dropped (mem_we=0).
REQ-034 reset SHALL take priority over start and over any transfer in the same cycle.

Verification
REQ-035 Basic: reset, start, base=0x000, length=4, bytes 0x12,0x34,0x56,0x78 back-to-back -> writes at 0x000..0x003 one cycle after each transfer, done pulse once, checksum=0x14.
REQ-036 Stall: length=2, in_valid low 3 cycles between bytes 0xFF,0x02 -> exactly 2 writes, no write during stall, checksum=0x01.
REQ-037 Wrap: base=0xFFE, length=4, bytes 0x01..0x04 -> write addresses 0xFFE,0xFFF,0x000,0x001, checksum=0x0A.
REQ-038 Bounds: length=0 -> done pulse 1 cycle after start, no mem_we; length=0x1001 -> err_len pulse, state stays IDLE, in_ready stays 0.
REQ-039 Abort: reset asserted on the cycle of the 2nd transfer of a 4-byte session -> only 1 write observed, all outputs at reset values next cycle, new start then works normally.
REQ-040 Handshake: in_valid held 1 with 6 bytes offered for length=4 -> exactly 4 accepted, in_ready=0 from DONE cycle on, start during LOAD ignored.
